// File: rtl/spi_frame_pkg.sv
// Shared types and frame geometry for the 6-byte SPI frame master.
//   state_t      : frame sequencer states
//   FRAME_*      : frame length in bytes / bits
//   RX_*         : width and first captured bit of the receive window
package spi_frame_pkg;

    localparam int unsigned FRAME_BYTES  = 6;
    localparam int unsigned FRAME_BITS   = FRAME_BYTES * 8;
    localparam int unsigned RX_BITS      = 32;
    localparam int unsigned RX_START_BIT = 16;
    localparam int unsigned BIT_CNT_W    = 6;
    localparam int unsigned PHASE_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter, registered SCLK level and edge strobes.
//   clk, resetn : system clock, async active-low reset
//   go          : request a rising edge (honoured at a low-phase end, or from idle once low long enough)
//   halt        : force SCLK low and stop immediately
//   sclk        : registered SCLK level (mode 0, idles low)
//   rise_c      : SCLK goes high at this clock edge
//   fall_c      : SCLK goes low at this clock edge (normal high-phase end)
//   low_end_c   : low half-period of a running period completes at this edge
module spi_clk_gen
    import spi_frame_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic go,
    input  logic halt,
    output logic sclk,
    output logic rise_c,
    output logic fall_c,
    output logic low_end_c
);

    localparam logic [PHASE_CNT_W-1:0] CNT_LAST = PHASE_CNT_W'(HALF_PERIOD - 1);

    logic                   active_q;
    logic                   low_ok_q;
    logic [PHASE_CNT_W-1:0] cnt_q;
    logic                   phase_end_c;

    assign phase_end_c = (cnt_q == CNT_LAST);
    assign low_end_c   = active_q & ~sclk & phase_end_c;
    assign fall_c      = active_q & sclk & phase_end_c & ~halt;
    // From idle, a rise is only allowed once SCLK has been low a full half-period
    // (matters after a truncated high phase caused by a halt).
    assign rise_c      = go & ~halt & (active_q ? low_end_c : (low_ok_q & ~sclk));

    // Phase counter and SCLK level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk     <= 1'b0;
            active_q <= 1'b0;
            low_ok_q <= 1'b1;
            cnt_q    <= '0;
        end else if (halt) begin
            sclk     <= 1'b0;
            active_q <= 1'b0;
            low_ok_q <= 1'b0;
            cnt_q    <= '0;
        end else if (rise_c) begin
            sclk     <= 1'b1;
            active_q <= 1'b1;
            low_ok_q <= 1'b0;
            cnt_q    <= '0;
        end else if (active_q) begin
            if (phase_end_c) begin
                cnt_q <= '0;
                if (sclk) begin
                    sclk <= 1'b0;
                end else begin
                    active_q <= 1'b0;
                    low_ok_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (!low_ok_q) begin
            if (phase_end_c) begin
                low_ok_q <= 1'b1;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 master sending one 48-bit frame per START and capturing MISO bytes 2..5.
//   clk, resetn     : system clock, async active-low reset
//   start, abort    : frame request / frame termination
//   tx_data         : frame bytes, [47:40] sent first
//   busy, done      : frame in progress / one-cycle completion pulse
//   rx_data         : MISO bytes 2..5 of the last completed frame, byte 2 in [31:24]
//   sclk, mosi, miso, cs : SPI pins (cs active-low)
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CS_SETUP    = 2,
    parameter int unsigned CS_HOLD     = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [RX_BITS-1:0]    rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    localparam logic [PHASE_CNT_W-1:0] SETUP_LAST = PHASE_CNT_W'(CS_SETUP - 1);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LAST  = PHASE_CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_CNT_W-1:0]   BIT_LAST   = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]   RX_PREV    = BIT_CNT_W'(RX_START_BIT - 1);

    state_t                  state_q, state_d;
    logic [PHASE_CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;
    logic [RX_BITS-1:0]      rx_sr_q, rx_sr_d;
    logic [RX_BITS-1:0]      rx_data_q, rx_data_d;
    logic                    cs_q, cs_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    mosi_q, mosi_d;
    logic                    go_c, halt_c;
    logic                    rise_c, fall_c, low_end_c;

    spi_clk_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_clk_gen (
        .clk       (clk),
        .resetn    (resetn),
        .go        (go_c),
        .halt      (halt_c),
        .sclk      (sclk),
        .rise_c    (rise_c),
        .fall_c    (fall_c),
        .low_end_c (low_end_c)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign mosi    = mosi_q;
    assign cs      = cs_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mosi_q    <= mosi_d;
        end
    end

    // Frame sequencer: next state, datapath and SCLK requests
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mosi_d    = mosi_q;
        go_c      = 1'b0;
        halt_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // done_q marks the completion cycle: guarantees one CS-high cycle between frames
                if (start && !abort && !done_q) begin
                    state_d = ST_SETUP;
                    tx_sr_d = tx_data;
                    mosi_d  = tx_data[FRAME_BITS-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                go_c = (cnt_q == SETUP_LAST);
                if (rise_c) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else if (!go_c) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                go_c = low_end_c && (bit_q != BIT_LAST);
                if (fall_c && (bit_q != BIT_LAST)) begin
                    tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                    mosi_d  = tx_sr_q[FRAME_BITS-2];
                end
                // bit_q counts the bit whose period is in progress; the rise starts bit_q+1
                if (rise_c) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q >= RX_PREV) begin
                        rx_sr_d = {rx_sr_q[RX_BITS-2:0], miso};
                    end
                end else if (low_end_c) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d   = ST_IDLE;
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sr_q;
                    cnt_d     = '0;
                    bit_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything outside IDLE
        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            cs_d      = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            mosi_d    = 1'b0;
            cnt_d     = '0;
            bit_d     = '0;
            tx_sr_d   = tx_sr_q;
            rx_sr_d   = rx_sr_q;
            rx_data_d = rx_data_q;
            go_c      = 1'b0;
            halt_c    = 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: default timing (a) and fastest timing (b).
module tb_spi_frame_master;

    typedef struct packed {
        logic [47:0] tx;
        logic [31:0] rx;
        logic [15:0] cslen;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_a, abort_a, busy_a, done_a, sclk_a, mosi_a, miso_a, cs_a;
    logic        start_b, abort_b, busy_b, done_b, sclk_b, mosi_b, miso_b, cs_b;
    logic [47:0] tx_a, tx_b;
    logic [31:0] rx_a, rx_b;

    logic [1:0]  cs_v, sclk_v, mosi_v, done_v;
    logic [47:0] resp    [2];
    logic [47:0] slv_sr  [2];
    logic [47:0] slv_cap [2];

    int          ph_len   [2];
    int          cs_len   [2];
    int          rises    [2];
    int          done_cnt [2];
    logic [1:0]  prev_cs, prev_sclk, prev_done;

    exp_t        sb_a [$];
    exp_t        sb_b [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    spi_frame_master #(.HALF_PERIOD(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut_a (
        .clk(clk), .resetn(resetn), .start(start_a), .abort(abort_a), .tx_data(tx_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a),
        .miso(miso_a), .cs(cs_a)
    );

    spi_frame_master #(.HALF_PERIOD(2), .CS_SETUP(1), .CS_HOLD(1)) u_dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .abort(abort_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b),
        .miso(miso_b), .cs(cs_b)
    );

    assign cs_v   = {cs_b, cs_a};
    assign sclk_v = {sclk_b, sclk_a};
    assign mosi_v = {mosi_b, mosi_a};
    assign done_v = {done_b, done_a};
    assign miso_a = slv_sr[0][47];
    assign miso_b = slv_sr[1][47];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int hp_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic exp_t mk(input logic [47:0] tx, input logic [31:0] rx, input logic [15:0] len);
        exp_t e;
        e.tx    = tx;
        e.rx    = rx;
        e.cslen = len;
        return e;
    endfunction

    function automatic bit sb_pop(input int d, output exp_t e);
        e = '0;
        if (d == 0) begin
            if (sb_a.size() == 0) return 1'b0;
            e = sb_a.pop_front();
        end else begin
            if (sb_b.size() == 0) return 1'b0;
            e = sb_b.pop_front();
        end
        return 1'b1;
    endfunction

    // Mode-0 slave, SCLK phase timing and completion scoreboard, sampled on the falling CLK edge
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] rxv;
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                ph_len[d]    = 1000;
                cs_len[d]    = 0;
                rises[d]     = 0;
                prev_cs[d]   = 1'b1;
                prev_sclk[d] = 1'b0;
                prev_done[d] = 1'b0;
                slv_sr[d]    = '0;
                slv_cap[d]   = '0;
            end else begin
                if (!cs_v[d]) begin
                    if (prev_cs[d]) begin
                        cs_len[d]  = 0;
                        rises[d]   = 0;
                        slv_sr[d]  = resp[d];
                        slv_cap[d] = '0;
                    end
                    cs_len[d]++;
                end
                if (sclk_v[d] != prev_sclk[d]) begin
                    if (prev_sclk[d]) begin
                        if (!cs_v[d]) chk($sformatf("hi_phase%0d", d), ph_len[d], hp_of(d));
                        slv_sr[d] = slv_sr[d] << 1;
                    end else begin
                        if (rises[d] > 0) chk($sformatf("lo_phase%0d", d), ph_len[d], hp_of(d));
                        else chk($sformatf("lo_first%0d", d), ph_len[d] >= hp_of(d), 1);
                        rises[d]++;
                        slv_cap[d] = {slv_cap[d][46:0], mosi_v[d]};
                    end
                    ph_len[d] = 1;
                end else begin
                    ph_len[d]++;
                end
                if (prev_done[d]) chk($sformatf("done_width%0d", d), done_v[d], 0);
                if (done_v[d]) begin
                    done_cnt[d]++;
                    rxv = (d == 0) ? rx_a : rx_b;
                    if (!sb_pop(d, e)) begin
                        chk($sformatf("unexp_done%0d", d), 1, 0);
                    end else begin
                        chk($sformatf("rx_data%0d", d), rxv, e.rx);
                        chk($sformatf("mosi_seq%0d", d), slv_cap[d], e.tx);
                        chk($sformatf("cs_len%0d", d), cs_len[d], e.cslen);
                        chk($sformatf("rises%0d", d), rises[d], 48);
                    end
                end
                prev_cs[d]   = cs_v[d];
                prev_sclk[d] = sclk_v[d];
                prev_done[d] = done_v[d];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input int target, input int budget);
        int n = 0;
        while (done_cnt[d] < target && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("done_wait%0d", d), done_cnt[d] >= target, 1);
    endtask

    task automatic wait_rise(input int d, input int target, input int budget);
        int n = 0;
        while (rises[d] < target && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("rise_wait%0d", d), rises[d] >= target, 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = 0;
            resp[d]     = '0;
        end
        resetn  = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; tx_a = '0;
        start_b = 1'b0; abort_b = 1'b0; tx_b = '0;
        repeat (3) tick();
        chk("rst_cs", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rx", rx_a, 0);
        chk("rst_cs_b", cs_b, 1);
        resetn = 1'b1;
        repeat (3) tick();

        // Basic frame with loopback data
        tx_a    = 48'h0102_A5C3_5A3C;
        resp[0] = 48'h0000_DEAD_BEEF;
        sb_a.push_back(mk(tx_a, 32'hDEAD_BEEF, 16'd388));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("accept_cs", cs_a, 0);
        chk("accept_busy", busy_a, 1);
        chk("accept_mosi", mosi_a, tx_a[47]);
        tx_a = 48'hFFFF_FFFF_FFFF;
        wait_done(0, 1, 600);
        repeat (10) tick();
        chk("done_once", done_cnt[0], 1);
        chk("rx_held", rx_a, 32'hDEAD_BEEF);

        // ABORT with START in IDLE: nothing happens
        abort_a = 1'b1;
        start_a = 1'b1;
        tick();
        abort_a = 1'b0;
        start_a = 1'b0;
        chk("idle_abort_busy", busy_a, 0);
        chk("idle_abort_cs", cs_a, 1);

        // ABORT after bit 20, during a high phase
        tx_a    = 48'hA5A5_5A5A_C3C3;
        resp[0] = 48'h1234_5678_9ABC;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_rise(0, 21, 400);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_cs", cs_a, 1);
        chk("abort_sclk", sclk_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_rx", rx_a, 32'hDEAD_BEEF);
        repeat (20) tick();
        chk("abort_no_done", done_cnt[0], 1);
        chk("abort_sclk_idle", sclk_a, 0);

        // START held for three frames
        tx_a    = 48'hF0E1_D2C3_B4A5;
        resp[0] = 48'h0000_1234_5678;
        repeat (3) sb_a.push_back(mk(tx_a, 32'h1234_5678, 16'd388));
        start_a = 1'b1;
        wait_done(0, 4, 1500);
        start_a = 1'b0;
        repeat (10) tick();
        chk("held_done_count", done_cnt[0], 4);
        chk("held_busy", busy_a, 0);

        // Asynchronous reset mid-SHIFT
        tx_a    = 48'h8000_0000_0001;
        resp[0] = 48'hFFFF_FFFF_FFFF;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_rise(0, 10, 300);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_cs", cs_a, 1);
        chk("mid_rst_sclk", sclk_a, 0);
        chk("mid_rst_rx", rx_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_mosi", mosi_a, 0);
        #12 resetn = 1'b1;
        repeat (5) tick();
        chk("post_rst_busy", busy_a, 0);
        chk("post_rst_cs", cs_a, 1);
        resp[0] = 48'hFFFF_CAFE_F00D;
        sb_a.push_back(mk(tx_a, 32'hCAFE_F00D, 16'd388));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done(0, 5, 600);

        // Fastest timing configuration
        tx_b    = 48'h5A5A_0F0F_C3C3;
        resp[1] = 48'hFFFF_0BAD_F00D;
        sb_b.push_back(mk(tx_b, 32'h0BAD_F00D, 16'd194));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_done(1, 1, 400);

        repeat (10) tick();
        chk("sb_a_empty", sb_a.size(), 0);
        chk("sb_b_empty", sb_b.size(), 0);
        chk("done_total_a", done_cnt[0], 5);
        chk("done_total_b", done_cnt[1], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
